turn_controller: RTL and testbench

Sequencing block on the player side of the tic-tac-toe board logic. It turns raw switch and button input into committed moves for the board, alternating between players. Each move goes out as a square code plus player code with a one-cycle strobe. The block samples the board's `valid` and `outcome` responses, rejects illegal moves, and declares the game over on a win, a loss or a full board. It sits between the top-level I/O (switches, keys, LEDs) and the board/move-checking block.

---
 rtl/game_pkg.sv | 53 +++++
 rtl/debounce_edge.sv | 46 ++++
 rtl/turn_controller.sv | 154 +++++++++++++++
 tb/tb_turn_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared tic-tac-toe codes: squares, players, outcomes, controller states
// and the committed-move payload.
package game_pkg;

  localparam int unsigned SQ_W  = 4;
  localparam int unsigned PL_W  = 2;
  localparam int unsigned OC_W  = 2;
  localparam int unsigned CNT_W = 4;

  localparam logic [SQ_W-1:0] SQ_A1 = SQ_W'(0);
  localparam logic [SQ_W-1:0] SQ_A2 = SQ_W'(1);
  localparam logic [SQ_W-1:0] SQ_A3 = SQ_W'(2);
  localparam logic [SQ_W-1:0] SQ_B1 = SQ_W'(3);
  localparam logic [SQ_W-1:0] SQ_B2 = SQ_W'(4);
  localparam logic [SQ_W-1:0] SQ_B3 = SQ_W'(5);
  localparam logic [SQ_W-1:0] SQ_C1 = SQ_W'(6);
  localparam logic [SQ_W-1:0] SQ_C2 = SQ_W'(7);
  localparam logic [SQ_W-1:0] SQ_C3 = SQ_W'(8);

  localparam logic [CNT_W-1:0] MAX_MOVES = CNT_W'(9);

  typedef enum logic [PL_W-1:0] {
    P_NONE = 2'b00,
    P1     = 2'b01,
    P2     = 2'b10
  } player_e;

  typedef enum logic [OC_W-1:0] {
    IN_PROGRESS = 2'd0,
    P1_WIN      = 2'd1,
    P1_LOSE     = 2'd2,
    TIE         = 2'd3
  } outcome_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_SUBMIT = 3'd2,
    S_SETTLE = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  typedef struct packed {
    logic [SQ_W-1:0] square;
    player_e         user;
  } move_t;

  function automatic player_e other_player(input player_e p);
    return (p == P1) ? P2 : P1;
  endfunction

endpackage

// File: rtl/debounce_edge.sv
// Synchronizes and debounces a raw pushbutton; emits the stable level and a
// one-cycle pulse on its rising edge.
module debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          rise  <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Collects debounced moves from the switches, submits them to the board,
// alternates players and declares the end of the game.
module turn_controller
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SQ_W-1:0]  sel_key,
  input  logic             confirm,
  input  logic             valid,
  input  logic [OC_W-1:0]  outcome,
  output logic [SQ_W-1:0]  move,
  output logic [PL_W-1:0]  user,
  output logic             move_stb,
  output logic             board_clr,
  output logic [PL_W-1:0]  turn,
  output logic [CNT_W-1:0] move_count,
  output logic             err,
  output logic             game_over,
  output logic [OC_W-1:0]  winner
);

  logic cfm_level;
  logic cfm_rise;
  logic cfm_pulse;

  debounce_edge #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .raw  (confirm),
    .level(cfm_level),
    .rise (cfm_rise)
  );

  // Rise and level update on the same edge; requiring both rejects a stray rise
  assign cfm_pulse = cfm_rise & cfm_level;

  state_e           state_q,  state_d;
  move_t            mv_q,     mv_d;
  logic             stb_q,    stb_d;
  logic             clr_q,    clr_d;
  player_e          turn_q,   turn_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             err_q,    err_d;
  logic             over_q,   over_d;
  logic [OC_W-1:0]  win_q,    win_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mv_q    <= '{square: '0, user: P_NONE};
      stb_q   <= 1'b0;
      clr_q   <= 1'b0;
      turn_q  <= P_NONE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      mv_q    <= mv_d;
      stb_q   <= stb_d;
      clr_q   <= clr_d;
      turn_q  <= turn_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      over_q  <= over_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mv_d    = mv_q;
    stb_d   = 1'b0;
    clr_d   = 1'b0;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    over_d  = over_q;
    win_d   = win_q;

    if (start) begin
      clr_d   = 1'b1;
      cnt_d   = '0;
      err_d   = 1'b0;
      win_d   = '0;
      over_d  = 1'b0;
      turn_d  = P1;
      state_d = S_SELECT;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_SELECT: begin
          if (cfm_pulse) begin
            if (sel_key > SQ_C3) begin
              err_d = 1'b1;
            end else begin
              mv_d    = '{square: sel_key, user: turn_q};
              err_d   = 1'b0;
              stb_d   = 1'b1;
              state_d = S_SUBMIT;
            end
          end
        end
        S_SUBMIT: begin
          if (valid) begin
            cnt_d   = (cnt_q == MAX_MOVES) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = S_SETTLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_SELECT;
          end
        end
        S_SETTLE: state_d = S_CHECK;
        S_CHECK: begin
          if (outcome == OC_W'(P1_WIN) || outcome == OC_W'(P1_LOSE)) begin
            win_d   = outcome;
            over_d  = 1'b1;
            turn_d  = P_NONE;
            state_d = S_DONE;
          end else if (cnt_q == MAX_MOVES) begin
            win_d   = OC_W'(TIE);
            over_d  = 1'b1;
            turn_d  = P_NONE;
            state_d = S_DONE;
          end else begin
            turn_d  = other_player(turn_q);
            state_d = S_SELECT;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign move       = mv_q.square;
  assign user       = mv_q.user;
  // A start landing on the submit cycle must cancel the commit immediately
  assign move_stb   = stb_q & ~start;
  assign board_clr  = clr_q;
  assign turn       = turn_q;
  assign move_count = cnt_q;
  assign err        = err_q;
  assign game_over  = over_q;
  assign winner     = win_q;

endmodule

// File: tb/tb_turn_controller.sv
// Randomized scoreboard bench for turn_controller against a game-rule model.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] sel_key;
  logic       confirm;
  logic       valid;
  logic [1:0] outcome;
  logic [3:0] move;
  logic [1:0] user;
  logic       move_stb;
  logic       board_clr;
  logic [1:0] turn;
  logic [3:0] move_count;
  logic       err;
  logic       game_over;
  logic [1:0] winner;

  turn_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel_key   (sel_key),
    .confirm   (confirm),
    .valid     (valid),
    .outcome   (outcome),
    .move      (move),
    .user      (user),
    .move_stb  (move_stb),
    .board_clr (board_clr),
    .turn      (turn),
    .move_count(move_count),
    .err       (err),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [5:0] exp_q[$];

  // Game-level reference: whose turn, moves made, error flag, result
  int m_play, m_turn, m_cnt, m_err, m_over, m_win;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_start();
    m_play = 1; m_turn = 1; m_cnt = 0; m_err = 0; m_over = 0; m_win = 0;
  endtask

  task automatic model_step(input int sel, input int v, input int oc);
    logic [3:0] sq;
    logic [1:0] pl;
    if (m_play == 0 || m_over != 0) return;
    if (sel > 8) begin
      m_err = 1;
      return;
    end
    sq = 4'(sel);
    pl = 2'(m_turn);
    exp_q.push_back({sq, pl});
    if (v == 0) begin
      m_err = 1;
      return;
    end
    m_err = 0;
    m_cnt++;
    if (oc == 1 || oc == 2) begin
      m_win = oc; m_over = 1;
    end else if (m_cnt == 9) begin
      m_win = 3; m_over = 1;
    end else begin
      m_turn = 3 - m_turn;
    end
  endtask

  task automatic check_state(input string tag);
    int exp_turn;
    exp_turn = (m_play != 0 && m_over == 0) ? m_turn : 0;
    chk({tag, ".turn"}, 32'(turn), exp_turn);
    chk({tag, ".move_count"}, 32'(move_count), m_cnt);
    chk({tag, ".err"}, 32'(err), m_err);
    chk({tag, ".game_over"}, 32'(game_over), m_over);
    chk({tag, ".winner"}, 32'(winner), m_win);
  endtask

  task automatic press(input int sel, input int v, input int oc, input int hold);
    sel_key = 4'(sel);
    valid   = v[0];
    outcome = 2'(oc);
    model_step(sel, v, oc);
    confirm = 1'b1;
    repeat (hold) @(posedge clk);
    #1 confirm = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_state($sformatf("press_sq%0d", sel));
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model_start();
    chk("start.board_clr_hi", 32'(board_clr), 1);
    check_state("start");
    @(posedge clk);
    #1 chk("start.board_clr_lo", 32'(board_clr), 0);
  endtask

  // Monitor: every strobe must match the oldest expected commit
  always @(negedge clk) begin
    if (rst && move_stb) begin
      logic [5:0] e;
      strobes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stb_unexpected got move=%0d user=%0d want none", move, user);
      end else begin
        e = exp_q.pop_front();
        if ({move, user} !== e) begin
          bad++;
          $display("FAIL stb_payload got move=%0d user=%0d want move=%0d user=%0d",
                   move, user, e[5:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    int s0;
    int r;
    int oc;
    rst = 1'b0; start = 1'b0; confirm = 1'b0; valid = 1'b0;
    sel_key = '0; outcome = '0;
    m_play = 0; m_turn = 0; m_cnt = 0; m_err = 0; m_over = 0; m_win = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.move", 32'(move), 0);
    chk("reset.user", 32'(user), 0);
    chk("reset.move_stb", 32'(move_stb), 0);
    chk("reset.board_clr", 32'(board_clr), 0);
    check_state("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Confirm in IDLE is ignored
    press(5, 1, 0, 10);

    do_start();
    press(4, 1, 0, 10);

    // Short glitch must not commit
    confirm = 1'b1;
    repeat (3) @(posedge clk);
    #1 confirm = 1'b0;
    repeat (12) @(posedge clk);
    #1 check_state("glitch");

    // Long hold gives exactly one commit
    s0 = strobes;
    press(5, 1, 0, 100);
    chk("hold_once", strobes - s0, 1);

    press(11, 1, 0, 10);
    press(2, 0, 0, 10);

    // P1 wins on the fifth accepted move
    do_start();
    press(0, 1, 0, 10);
    press(3, 1, 0, 10);
    press(1, 1, 0, 10);
    press(4, 1, 0, 10);
    press(2, 1, 1, 10);
    press(6, 1, 0, 10);

    // Full board with no line
    do_start();
    for (int i = 0; i < 9; i++) press(i, 1, 3, 10);
    do_start();

    // Start on the submit cycle cancels the commit
    sel_key = 4'd7; valid = 1'b1; outcome = 2'd0;
    confirm = 1'b1;
    repeat (7) @(posedge clk);
    #1 start = 1'b1;
    #1 chk("sub_start.move_stb", 32'(move_stb), 0);
    @(posedge clk);
    #1 start = 1'b0;
    model_start();
    chk("sub_start.board_clr", 32'(board_clr), 1);
    check_state("sub_start");
    confirm = 1'b0;
    repeat (12) @(posedge clk);
    #1 check_state("sub_start_after");

    // Random play across several games
    for (int g = 0; g < 40; g++) begin
      if (m_over != 0) do_start();
      r = int'($urandom % 10);
      oc = (r < 6) ? 0 : (r < 8) ? 3 : (r == 8) ? 1 : 2;
      press(int'($urandom_range(0, 11)), int'(($urandom % 4) != 0), oc, 10);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
